// File: rtl/iob_diff.sv
// rtl/iob_diff.sv - sample-to-increment differencer (inverse accumulator); optional IOB_DIFF_SAT_EN saturating mode
module iob_diff #(
  parameter int                DATA_W     = 21,
  parameter logic [DATA_W-1:0] RST_VAL    = {DATA_W{1'b0}},
  parameter bit                DROP_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] incr_o,
  output logic              ovf_o
);

  typedef enum logic {EMPTY, PRIMED} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] prev;
  logic              accept;
  logic              emit;
  logic [DATA_W-1:0] diff;
  logic              diff_ovf;

  // A restart blocks the input; otherwise the output slot is free or draining now.
  assign in_ready_o = !clr_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && cke_i;

`ifdef IOB_DIFF_SAT_EN
  logic signed [DATA_W:0] wide;

  // Signed difference one bit wider, clamped to the DATA_W signed range.
  always_comb begin
    wide     = $signed({data_i[DATA_W-1], data_i}) - $signed({prev[DATA_W-1], prev});
    diff     = wide[DATA_W-1:0];
    diff_ovf = 1'b0;
    if (wide[DATA_W] != wide[DATA_W-1]) begin
      diff_ovf = 1'b1;
      diff     = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Modular difference: exact inverse of a wrapping accumulator.
  always_comb begin
    diff     = data_i - prev;
    diff_ovf = 1'b0;
  end
`endif

  // Next state and emit decision; prev already holds RST_VAL while EMPTY.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (clr_i) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      state_nxt = PRIMED;
      emit      = (state == PRIMED) || !DROP_FIRST;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) state <= EMPTY;
      else       state <= state_nxt;
    end
  end

  // Previous-sample register.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i || clr_i) prev <= RST_VAL;
      else if (accept)    prev <= data_i;
    end
  end

  // One-deep output stage: load on emit, clear valid on drain, flush on restart.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i || clr_i) begin
        out_valid_o <= 1'b0;
        incr_o      <= '0;
        ovf_o       <= 1'b0;
      end else if (emit) begin
        out_valid_o <= 1'b1;
        incr_o      <= diff;
        ovf_o       <= diff_ovf;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iob_diff.sv
// tb/tb_iob_diff.sv - self-checking bench for iob_diff (default build)
module tb_iob_diff;

  localparam int W = 21;

  logic         clk = 1'b0;
  logic         cke, rst, clr, in_valid, out_ready;
  logic [W-1:0] data;
  logic         in_ready, out_valid, ovf;
  logic [W-1:0] incr;
  logic         in_ready_d, out_valid_d, ovf_d;
  logic [W-1:0] incr_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iob_diff #(.DATA_W(W), .RST_VAL('0), .DROP_FIRST(1'b0)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .data_i(data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .incr_o(incr), .ovf_o(ovf)
  );

  iob_diff #(.DATA_W(W), .RST_VAL('0), .DROP_FIRST(1'b1)) dut_d (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready_d), .data_i(data),
    .out_valid_o(out_valid_d), .out_ready_i(out_ready), .incr_o(incr_d), .ovf_o(ovf_d)
  );

  typedef struct {
    bit           cke;
    bit           clr;
    bit           vld;
    logic [W-1:0] data;
    bit           ordy;
    bit           e_rdy;
    bit           e_ov;
    logic [W-1:0] e_incr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit c, bit cl, bit v, logic [W-1:0] d, bit o,
                              bit er, bit eo, logic [W-1:0] ei);
    vec_t t;
    t.cke = c; t.clr = cl; t.vld = v; t.data = d; t.ordy = o;
    t.e_rdy = er; t.e_ov = eo; t.e_incr = ei;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cke = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] sum, cur_inc, exp_inc;
    logic [W-1:0] q[$];
    bit           have;
    int           sent, rcv;
    localparam int N = 3000;

    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_incr", {11'd0, incr}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    //    cke clr vld data        ordy rdy ov incr
    add(1, 0, 1, 21'd5,       1, 1, 1, 21'd5);
    add(1, 0, 1, 21'd12,      1, 1, 1, 21'd7);
    add(1, 0, 1, 21'd12,      1, 1, 1, 21'd0);
    add(1, 0, 1, 21'd20,      1, 1, 1, 21'd8);
    add(1, 0, 0, 21'd0,       1, 1, 0, 21'd0);
    add(1, 0, 1, 21'h1FFFFE,  1, 1, 1, 21'h1FFFEA);
    add(1, 0, 1, 21'h000002,  1, 1, 1, 21'h000004);
    add(1, 0, 1, 21'd10,      0, 0, 1, 21'h000004);
    add(1, 0, 1, 21'd10,      0, 0, 1, 21'h000004);
    add(1, 0, 1, 21'd10,      1, 1, 1, 21'd8);
    add(1, 0, 1, 21'd15,      1, 1, 1, 21'd5);
    add(1, 1, 1, 21'd99,      0, 0, 0, 21'd0);
    add(1, 0, 1, 21'd7,       1, 1, 1, 21'd7);
    add(1, 0, 0, 21'd0,       0, 0, 1, 21'd7);
    add(1, 0, 0, 21'd0,       1, 1, 0, 21'd0);
    add(0, 0, 1, 21'd50,      1, 1, 0, 21'd0);
    add(1, 0, 1, 21'd50,      1, 1, 1, 21'd43);
    add(0, 0, 0, 21'd0,       1, 1, 1, 21'd43);
    add(1, 0, 0, 21'd0,       1, 1, 0, 21'd0);

    foreach (tbl[i]) begin
      @(negedge clk);
      cke = tbl[i].cke; clr = tbl[i].clr; in_valid = tbl[i].vld;
      data = tbl[i].data; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_incr", i), {11'd0, incr}, {11'd0, tbl[i].e_incr});
        chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, 32'd0);
      end
    end

    // DROP_FIRST=1: first sample only primes
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; data = 21'd100; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drop_first_no_beat", {31'd0, out_valid_d}, 32'd0);
    @(negedge clk);
    data = 21'd103;
    @(posedge clk); #1;
    chk("drop_second_valid", {31'd0, out_valid_d}, 32'd1);
    chk("drop_second_incr", {11'd0, incr_d}, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drop_single_beat", {31'd0, out_valid_d}, 32'd0);

    // Loopback: accumulator model feeding the DUT, random valid/ready/cke
    do_reset();
    sum = '0; cur_inc = '0; have = 1'b0; sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 60000 && rcv < N; cyc++) begin
      @(negedge clk);
      if (!have && sent < N && $urandom_range(0, 1) == 1) begin
        cur_inc = W'($urandom);
        sum     = sum + cur_inc;
        have    = 1'b1;
      end
      in_valid  = have;
      data      = sum;
      out_ready = ($urandom_range(0, 2) != 0);
      cke       = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready && cke) begin
        if (q.size() == 0) begin
          chk("loop_spurious_beat", 32'd1, 32'd0);
        end else begin
          exp_inc = q.pop_front();
          chk("loop_incr", {11'd0, incr}, {11'd0, exp_inc});
        end
        rcv++;
      end
      if (in_valid && in_ready && cke) begin
        q.push_back(cur_inc);
        have = 1'b0;
        sent++;
      end
      @(posedge clk);
    end
    chk("loop_beat_count", rcv, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
